alu_op_sequencer: RTL
=====================

Name: alu_op_sequencer

Overview:
- Command-level controller in front of the parameterised ALU (ALUFUN 4-bit code, CNVZ flag nibble).
- Accepts one command at a time over a valid/ready handshake and registers the operands.
- Drives the ALU from those registers, captures result and flags, and returns them over a valid/ready response channel.
- Also sequences a multi-cycle unsigned multiply as repeated ALU additions, so the datapath needs no dedicated multiplier.

Parameters:
- bus, 4, data width; must match the ALU instance bus.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_mul  input  1  1 = multiply command; cmd_fun is ignored
- cmd_fun  input  4  ALUFUN code for single-cycle ops
- cmd_a  input  bus  operand A / multiplicand
- cmd_b  input  bus  operand B / multiplier
- alu_a  output  bus  to ALU a
- alu_b  output  bus  to ALU b
- alu_fun  output  4  to ALU ALUFUN
- alu_s  input  bus  from ALU s
- alu_cnvz  input  4  from ALU CNVZ
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  bus  result
- rsp_cnvz  output  4  flags {C,N,V,Z}
- rsp_err  output  1  command was illegal

Behaviour:
- Reset state (async, immediate): state=IDLE, cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_cnvz=0, rsp_err=0, alu_a=alu_b=0, alu_fun=0, all internal registers 0.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch a, b, fun, mul.
  - Go to EXEC if mul=0, or to MUL if mul=1.
- State EXEC (1 cycle):
  - alu_a/alu_b/alu_fun driven from latched registers.
  - At cycle end, capture alu_s -> rsp_result and alu_cnvz -> rsp_cnvz; go to DONE.
- State MUL (exactly bus cycles; iteration counter 0..bus-1, wraps to 0 on exit):
  - Registers: acc (init 0), mcand (init a), mplr (init b).
  - alu_a=acc, alu_b=mcand, alu_fun=4'b1000 (add).
  - Each cycle: if mplr[0]=1 then acc<=alu_s, else acc unchanged.
  - Each cycle: mcand<=mcand<<1, mplr<=mplr>>1 (logical; shifts internal, not via ALU).
  - After the last iteration: rsp_result <= low bus bits of a*b.
  - Flags: C=0, V=0, N=result[bus-1], Z=(result==0). Go to DONE.
- State DONE:
  - rsp_valid=1; rsp_result/rsp_cnvz/rsp_err held stable while rsp_ready=0.
  - On rsp_ready=1, go to IDLE next cycle; rsp_valid drops.
  - cmd_ready=0; no new command accepted in the same cycle as response acceptance.
- cmd_ready=0 in EXEC, MUL and DONE; cmd_valid is ignored there.
- Latency from accept edge to rsp_valid rising:
  - single op: 2 cycles
  - multiply: bus+1 cycles
- Outside EXEC/MUL, alu_a/alu_b/alu_fun hold their last values.
- Reset mid-operation: aborts immediately to the reset state; any in-flight result is discarded.
- Operand change on cmd_* after acceptance has no effect.
- rsp_err=0 for all legal commands.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: multiply supported as above.
- Undefined:
  - No MUL state and no acc/mcand/mplr/counter logic.
  - A command with cmd_mul=1 is accepted, skips EXEC and goes to DONE one cycle after acceptance.
  - Response: rsp_err=1, rsp_result=0, rsp_cnvz=0.
  - ALU outputs are not updated.

Test Plan:
- Reset, bus=4: rst pulse during MUL iteration 2 -> outputs immediately at reset values; next command ADD 3+4 returns 0111, cnvz 0000.
- ADD a=0111 b=0001 fun=1000 -> rsp_result=1000, rsp_cnvz=0110, rsp_valid 2 cycles after accept.
- SUB a=0101 b=0101 fun=1001 -> rsp_result=0000, rsp_cnvz=1001.
- MUL with ALU_SEQ_MUL_EN: 0011*0101 -> 1111, cnvz 0100, rsp_valid 5 cycles after accept. 0110*0011 -> 0010, cnvz 0000. 0000*1111 -> 0000, cnvz 0001.
- Backpressure: rsp_ready=0 for 3 cycles after ADD 1+1 -> rsp_result=0010 held and cmd_ready=0 throughout; a cmd_valid pulse in that window is not accepted; cmd_ready returns 1 the cycle after rsp_ready=1.
- Without ALU_SEQ_MUL_EN: cmd_mul=1, a=0011, b=0101 -> rsp_err=1, rsp_result=0000, rsp_cnvz=0000, rsp_valid 2 cycles after accept.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, ALU and response signals of the ALU operation
// sequencer. The master modport is the host/ALU side; the slave modport is the
// sequencer itself.
interface alu_op_sequencer_if #(
   parameter int bus = 4
);
   logic           cmd_valid;
   logic           cmd_ready;
   logic           cmd_mul;
   logic [3:0]     cmd_fun;
   logic [bus-1:0] cmd_a;
   logic [bus-1:0] cmd_b;
   logic [bus-1:0] alu_a;
   logic [bus-1:0] alu_b;
   logic [3:0]     alu_fun;
   logic [bus-1:0] alu_s;
   logic [3:0]     alu_cnvz;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [bus-1:0] rsp_result;
   logic [3:0]     rsp_cnvz;
   logic           rsp_err;

   modport master (
      output cmd_valid, cmd_mul, cmd_fun, cmd_a, cmd_b,
      input  cmd_ready,
      input  alu_a, alu_b, alu_fun,
      output alu_s, alu_cnvz,
      input  rsp_valid, rsp_result, rsp_cnvz, rsp_err,
      output rsp_ready
   );

   modport slave (
      input  cmd_valid, cmd_mul, cmd_fun, cmd_a, cmd_b,
      output cmd_ready,
      output alu_a, alu_b, alu_fun,
      input  alu_s, alu_cnvz,
      output rsp_valid, rsp_result, rsp_cnvz, rsp_err,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU command at a time, drives an external ALU
// from registered operands and returns result/flags on a response channel.
// Optional macro ALU_SEQ_MUL_EN adds an unsigned multiply built from bus
// repeated ALU additions (shift-and-add); without it a multiply command is
// answered with rsp_err=1 and the ALU outputs are left untouched.
module alu_op_sequencer #(
   parameter int bus = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_op_sequencer_if.slave    sif
);

   localparam logic [3:0] FUN_ADD = 4'b1000;

`ifdef ALU_SEQ_MUL_EN
   localparam int             CW        = (bus > 1) ? $clog2(bus) : 1;
   localparam logic [CW-1:0]  LAST_ITER = CW'(bus - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2,
      ST_MUL  = 2'd3
   } state_t;

   // Flags of a multiply result: no carry/overflow, sign and zero from the value.
   function automatic logic [3:0] mul_flags(input logic [bus-1:0] res);
      mul_flags = {1'b0, res[bus-1], 1'b0, (res == {bus{1'b0}})};
   endfunction
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2,
      ST_REJ  = 2'd3
   } state_t;
`endif

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_accept;
   logic            w_cmd_ready_nxt;
   logic            w_rsp_valid_nxt;

   logic            r_cmd_ready;
   logic            r_rsp_valid;
   logic [bus-1:0]  r_rsp_result;
   logic [3:0]      r_rsp_cnvz;
   logic            r_rsp_err;
   logic [bus-1:0]  r_alu_a;
   logic [bus-1:0]  r_alu_b;
   logic [3:0]      r_alu_fun;

`ifdef ALU_SEQ_MUL_EN
   logic [bus-1:0]  r_acc;
   logic [bus-1:0]  r_mcand;
   logic [bus-1:0]  r_mplr;
   logic [CW-1:0]   r_cnt;
   logic [bus-1:0]  w_acc_nxt;
   logic [bus-1:0]  w_mcand_nxt;

   // Partial product is added in only when the current multiplier bit is set.
   assign w_acc_nxt   = r_mplr[0] ? sif.alu_s : r_acc;
   assign w_mcand_nxt = r_mcand << 1;
`endif

   // State register plus the registered handshake outputs that follow it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
      end
   end

   // Next-state decode; handshake outputs are precomputed from the next state.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (sif.cmd_valid && r_cmd_ready) begin
               w_accept = 1'b1;
               if (sif.cmd_mul) begin
`ifdef ALU_SEQ_MUL_EN
                  w_state_nxt = ST_MUL;
`else
                  w_state_nxt = ST_REJ;
`endif
               end else begin
                  w_state_nxt = ST_EXEC;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_EXEC: begin
            w_state_nxt = ST_DONE;
         end
`ifdef ALU_SEQ_MUL_EN
         ST_MUL: begin
            if (r_cnt == LAST_ITER) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_MUL;
            end
         end
`else
         ST_REJ: begin
            w_state_nxt = ST_DONE;
         end
`endif
         ST_DONE: begin
            if (sif.rsp_ready) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
      w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
      w_rsp_valid_nxt = (w_state_nxt == ST_DONE);
   end

   // Operand capture, ALU drive, multiply iteration and response capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_result <= {bus{1'b0}};
         r_rsp_cnvz   <= 4'b0000;
         r_rsp_err    <= 1'b0;
         r_alu_a      <= {bus{1'b0}};
         r_alu_b      <= {bus{1'b0}};
         r_alu_fun    <= 4'b0000;
`ifdef ALU_SEQ_MUL_EN
         r_acc        <= {bus{1'b0}};
         r_mcand      <= {bus{1'b0}};
         r_mplr       <= {bus{1'b0}};
         r_cnt        <= {CW{1'b0}};
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (!sif.cmd_mul) begin
                     r_alu_a   <= sif.cmd_a;
                     r_alu_b   <= sif.cmd_b;
                     r_alu_fun <= sif.cmd_fun;
                  end else begin
`ifdef ALU_SEQ_MUL_EN
                     // First iteration adds the multiplicand onto a zero accumulator.
                     r_acc     <= {bus{1'b0}};
                     r_mcand   <= sif.cmd_a;
                     r_mplr    <= sif.cmd_b;
                     r_cnt     <= {CW{1'b0}};
                     r_alu_a   <= {bus{1'b0}};
                     r_alu_b   <= sif.cmd_a;
                     r_alu_fun <= FUN_ADD;
`else
                     // Rejected multiply leaves the ALU drive untouched.
                     r_alu_a   <= r_alu_a;
`endif
                  end
               end
            end
            ST_EXEC: begin
               r_rsp_result <= sif.alu_s;
               r_rsp_cnvz   <= sif.alu_cnvz;
               r_rsp_err    <= 1'b0;
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
               r_acc   <= w_acc_nxt;
               r_mcand <= w_mcand_nxt;
               r_mplr  <= r_mplr >> 1;
               if (r_cnt == LAST_ITER) begin
                  r_cnt        <= {CW{1'b0}};
                  r_rsp_result <= w_acc_nxt;
                  r_rsp_cnvz   <= mul_flags(w_acc_nxt);
                  r_rsp_err    <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                  r_alu_a <= w_acc_nxt;
                  r_alu_b <= w_mcand_nxt;
               end
            end
`else
            ST_REJ: begin
               r_rsp_result <= {bus{1'b0}};
               r_rsp_cnvz   <= 4'b0000;
               r_rsp_err    <= 1'b1;
            end
`endif
            ST_DONE: begin
               r_rsp_result <= r_rsp_result;
            end
            default: begin
               r_rsp_result <= r_rsp_result;
            end
         endcase
      end
   end

   assign sif.cmd_ready  = r_cmd_ready;
   assign sif.rsp_valid  = r_rsp_valid;
   assign sif.rsp_result = r_rsp_result;
   assign sif.rsp_cnvz   = r_rsp_cnvz;
   assign sif.rsp_err    = r_rsp_err;
   assign sif.alu_a      = r_alu_a;
   assign sif.alu_b      = r_alu_b;
   assign sif.alu_fun    = r_alu_fun;

endmodule
